// File: rtl/learn_note_feeder.sv
// Learn-mode song feeder: turns song ROM entries into falling-block display rows.
// Define FEEDER_LOOP_EN to restart the song at its end instead of stopping in DONE.
module learn_note_feeder #(
  parameter int ADDR_W    = 8,
  parameter int LEAD_ROWS = 13,
  parameter int GAP_ROWS  = 1
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              advance,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [13:0]       rom_data,
  output logic [7:0]        note,
  output logic [1:0]        shift,
  output logic              output_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_FETCH, S_WAIT,
    S_PLAY, S_GAP, S_DONE
  } state_e;

  localparam logic [3:0] LEAD_C = 4'(LEAD_ROWS);
  localparam logic [3:0] GAP_C  = 4'(GAP_ROWS);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        note_q;
  logic [1:0]        shift_q;
  logic              rdy_q;
  logic              busy_q;
  logic              done_q;

  logic acc;
  logic step;
  logic fin;

  assign acc  = advance & ~pause;
  assign step = acc | pend_q;

  // End marker, or the last row of the last addressable entry
  assign fin =
    (state_q == S_WAIT && rom_data[11:8] == 4'd0) ||
    (state_q == S_PLAY && step && cnt_q == 4'd1 &&
     addr_q == ADDR_MAX);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      note_q  <= 8'd0;
      shift_q <= 2'd0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fin) begin
        pend_q <= 1'b0;
        note_q <= 8'd0;
        rdy_q  <= 1'b0;
        done_q <= 1'b1;
`ifdef FEEDER_LOOP_EN
        state_q <= S_LEAD;
        addr_q  <= '0;
        cnt_q   <= LEAD_C;
        busy_q  <= 1'b1;
`else
        state_q <= S_DONE;
        busy_q  <= 1'b0;
`endif
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            done_q <= (state_q == S_DONE);
            if (start) begin
              state_q <= S_LEAD;
              addr_q  <= '0;
              cnt_q   <= LEAD_C;
              pend_q  <= 1'b0;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          S_LEAD, S_GAP: begin
            if (cnt_q == 4'd0) begin
              state_q <= S_FETCH;
            end else if (acc) begin
              cnt_q <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) state_q <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (acc) pend_q <= 1'b1;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (acc) pend_q <= 1'b1;
            note_q  <= rom_data[7:0];
            shift_q <= rom_data[13:12];
            rdy_q   <= 1'b1;
            cnt_q   <= rom_data[11:8];
            state_q <= S_PLAY;
          end
          S_PLAY: begin
            pend_q <= 1'b0;
            if (step) begin
              if (cnt_q <= 4'd1) begin
                addr_q <= addr_q + ADDR_W'(1);
                note_q <= 8'd0;
                rdy_q  <= 1'b0;
                cnt_q  <= GAP_C;
                state_q <= (GAP_C == 4'd0) ? S_FETCH : S_GAP;
              end else begin
                cnt_q <= cnt_q - 4'd1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rom_addr     = addr_q;
  assign note         = note_q;
  assign shift        = shift_q;
  assign output_ready = rdy_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_learn_note_feeder.sv
// Self-checking bench for learn_note_feeder: row scoreboard plus corner sequences.
module tb_learn_note_feeder;

  localparam int AW   = 4;
  localparam int NROM = 16;

  logic          vga_clk = 1'b0;
  logic          rst_n   = 1'b0;
  logic          start   = 1'b0;
  logic          pause   = 1'b0;
  logic          advance = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [13:0]   rom_data;
  logic [7:0]    note;
  logic [1:0]    shift;
  logic          output_ready;
  logic          busy;
  logic          done;

  logic [13:0] rom [NROM];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  prev_sh = 2'b00;

  typedef struct {
    logic       b;
    logic [7:0] n;
    logic [1:0] s;
    logic       r;
  } row_t;
  row_t q[$];

  typedef struct {
    logic [1:0] sh;
    logic [3:0] len;
    logic [7:0] nt;
  } vec_t;

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_data <= rom[rom_addr];

  learn_note_feeder #(.ADDR_W(AW)) u_dut (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .start        (start),
    .pause        (pause),
    .advance      (advance),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .shift        (shift),
    .output_ready (output_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_adv();
    advance = 1'b1;
    tick();
    advance = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_start(input bit with_adv);
    start   = 1'b1;
    advance = with_adv;
    tick();
    start   = 1'b0;
    advance = 1'b0;
    repeat (4) tick();
  endtask

  task automatic lead_in();
    repeat (13) pulse_adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    prev_sh = 2'b00;
  endtask

  task automatic run_song(input bit with_adv, input string nm);
    int   dn;
    row_t e;
    dn = 0;
    q.delete();
    repeat (13) q.push_back('{1'b1, 8'h00, prev_sh, 1'b0});
    for (int i = 0; i < NROM; i++) begin
      logic [13:0] w;
      w = rom[i];
      if (w[11:8] == 4'd0) break;
      repeat (w[11:8]) q.push_back('{1'b1, w[7:0], w[13:12], 1'b1});
      prev_sh = w[13:12];
      if (i == NROM - 1) break;
      q.push_back('{1'b1, 8'h00, w[13:12], 1'b0});
    end
    do_start(with_adv);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(nm, {busy, note, shift, output_ready},
          {e.b, e.n, e.s, e.r});
      advance = 1'b1;
      tick();
      advance = 1'b0;
      dn = int'(done);
      repeat (4) begin
        tick();
        dn += int'(done);
      end
    end
`ifdef FEEDER_LOOP_EN
    chk({nm, "_done_pulse"}, dn, 1);
    chk({nm, "_loop"}, {busy, rom_addr}, {1'b1, 4'h0});
    do_reset();
`else
    chk({nm, "_end"}, {done, busy, output_ready, note},
        {1'b1, 1'b0, 1'b0, 8'h00});
`endif
  endtask

  initial begin
    vec_t vt [4];
    int   dn;
    vt[0] = '{2'b10, 4'd3,  8'h40};
    vt[1] = '{2'b01, 4'd1,  8'h08};
    vt[2] = '{2'b11, 4'd5,  8'h7f};
    vt[3] = '{2'b00, 4'd15, 8'h80};
    for (int i = 0; i < NROM; i++) rom[i] = 14'h0;

    repeat (2) tick();
    chk("reset", {rom_addr, note, shift, output_ready, busy, done},
        32'h0);
    rst_n = 1'b1;
    tick();

    rom[0] = {2'b00, 4'd2, 8'h01};
    rom[1] = 14'h0;
    run_song(1'b0, "song1");

    for (int k = 0; k < 4; k++) begin
      rom[0] = {vt[k].sh, vt[k].len, vt[k].nt};
      rom[1] = 14'h0;
      run_song(1'b0, $sformatf("vec%0d", k));
    end

    for (int k = 0; k < 3; k++)
      rom[k] = {vt[k].sh, vt[k].len, vt[k].nt};
    rom[3] = 14'h0;
    run_song(1'b1, "multi_startadv");

    rom[0] = {2'b10, 4'd3, 8'h40};
    rom[1] = 14'h0;
    do_start(1'b0);
    lead_in();
    chk("pause_pre", {note, shift, output_ready}, {8'h40, 2'b10, 1'b1});
    pulse_adv();
    pause = 1'b1;
    repeat (5) pulse_adv();
    pause = 1'b0;
    chk("pause_hold", {note, shift, output_ready}, {8'h40, 2'b10, 1'b1});
    do_start(1'b0);
    chk("start_ignored", {busy, note, output_ready},
        {1'b1, 8'h40, 1'b1});
    pulse_adv();
    chk("pause_row2", {note, output_ready}, {8'h40, 1'b1});
    pulse_adv();
    chk("pause_gap", {note, shift, output_ready}, {8'h00, 2'b10, 1'b0});
    pulse_adv();
    prev_sh = 2'b10;
`ifdef FEEDER_LOOP_EN
    do_reset();
`else
    chk("pause_done", {done, busy}, {1'b1, 1'b0});
`endif

    rom[0] = {2'b01, 4'd1, 8'h01};
    rom[1] = {2'b00, 4'd2, 8'h04};
    rom[2] = 14'h0;
    do_start(1'b0);
    lead_in();
    chk("pend_row0", {note, shift, output_ready}, {8'h01, 2'b01, 1'b1});
    pulse_adv();
    chk("pend_gap", {note, shift, output_ready}, {8'h00, 2'b01, 1'b0});
    advance = 1'b1;
    tick();
    advance = 1'b0;
    tick();
    advance = 1'b1;
    tick();
    tick();
    advance = 1'b0;
    repeat (4) tick();
    chk("pend_row1", {note, shift, output_ready}, {8'h04, 2'b00, 1'b1});
    pulse_adv();
    chk("pend_used", {note, output_ready}, {8'h00, 1'b0});
    pulse_adv();
    prev_sh = 2'b00;
`ifdef FEEDER_LOOP_EN
    do_reset();
`else
    chk("pend_done", {done, busy}, {1'b1, 1'b0});
`endif

    for (int i = 0; i < NROM; i++)
      rom[i] = {2'(i % 4), 4'd1, 8'(1 << (i % 8))};
    run_song(1'b0, "wrap");

    for (int i = 0; i < NROM; i++) rom[i] = 14'h0;
    rom[0] = {2'b00, 4'd2, 8'h01};
    do_start(1'b0);
    lead_in();
    chk("rst_pre", {note, output_ready, busy}, {8'h01, 1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {rom_addr, note, shift, output_ready, busy, done},
        32'h0);
    tick();
    rst_n = 1'b1;
    prev_sh = 2'b00;
    tick();
    run_song(1'b0, "replay");

`ifdef FEEDER_LOOP_EN
    rom[0] = {2'b00, 4'd1, 8'h02};
    rom[1] = 14'h0;
    do_start(1'b0);
    lead_in();
    chk("loop_row", {note, output_ready}, {8'h02, 1'b1});
    pulse_adv();
    advance = 1'b1;
    tick();
    advance = 1'b0;
    dn = int'(done);
    repeat (4) begin
      tick();
      dn += int'(done);
    end
    chk("loop_pulse", dn, 1);
    chk("loop_addr", {busy, rom_addr, output_ready}, {1'b1, 4'h0, 1'b0});
    lead_in();
    chk("loop_again", {note, output_ready}, {8'h02, 1'b1});
`else
    dn = 0;
    chk("idle_hold", {done, busy, output_ready}, {1'b1, 1'b0, 1'b0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
